// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station and its helpers.
package reservation_station_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 5;

    localparam logic [OP_W-1:0] OP_NOP = 5'b11111;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              wj;
        logic              wk;
        logic [DATA_W-1:0] imm;
        logic              has_imm;
        logic [TAG_W-1:0]  dest;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_select.sv
// Combinational lowest-index priority encoder over a request vector.
module rs_select #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    // Scan from the top so the lowest set bit is the last writer.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_c = 1'b1;
                idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ops, wakes operands from the CDB,
// and issues the lowest-index ready entry to the ALU each cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SLACK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [OP_W-1:0]   op_in,
    input  logic [DATA_W-1:0] vj_in,
    input  logic [DATA_W-1:0] vk_in,
    input  logic [TAG_W-1:0]  qj_in,
    input  logic [TAG_W-1:0]  qk_in,
    input  logic              qj_wait_in,
    input  logic              qk_wait_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic              has_imm_in,
    input  logic [TAG_W-1:0]  dest_in,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              rs_full,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [TAG_W-1:0]  alu_dest
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = IDX_W + 1;
    localparam int unsigned FULL_MARK = DEPTH - SLACK;

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    rs_entry_t        new_entry;
    rs_entry_t        issue_entry;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] ready_vec;
    logic             free_found;
    logic             ready_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] ready_idx;
    logic             dispatch;
    logic             issue;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            free_vec[i]  = !entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid && !entries_q[i].wj && !entries_q[i].wk;
        end
    end

    rs_select #(.N(DEPTH)) u_free_sel (
        .req     (free_vec),
        .found_c (free_found),
        .idx_c   (free_idx)
    );

    rs_select #(.N(DEPTH)) u_ready_sel (
        .req     (ready_vec),
        .found_c (ready_found),
        .idx_c   (ready_idx)
    );

    assign dispatch    = (op_in != OP_NOP) && free_found;
    assign issue       = ready_found;
    assign issue_entry = entries_q[ready_idx];

    // Incoming instruction, with same-cycle CDB forwarding so no broadcast is missed.
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.op      = op_in;
        new_entry.vj      = vj_in;
        new_entry.vk      = vk_in;
        new_entry.qj      = qj_in;
        new_entry.qk      = qk_in;
        new_entry.wj      = qj_wait_in;
        new_entry.wk      = qk_wait_in && !has_imm_in;
        new_entry.imm     = imm_in;
        new_entry.has_imm = has_imm_in;
        new_entry.dest    = dest_in;
        if (cdb_valid && new_entry.wj && (qj_in == cdb_tag)) begin
            new_entry.vj = cdb_value;
            new_entry.wj = 1'b0;
        end
        if (cdb_valid && new_entry.wk && (qk_in == cdb_tag)) begin
            new_entry.vk = cdb_value;
            new_entry.wk = 1'b0;
        end
    end

    // Wake-up, issue retirement and dispatch write; free and ready slots never coincide.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (cdb_valid && entries_q[i].valid) begin
                if (entries_q[i].wj && (entries_q[i].qj == cdb_tag)) begin
                    entries_d[i].vj = cdb_value;
                    entries_d[i].wj = 1'b0;
                end
                if (entries_q[i].wk && (entries_q[i].qk == cdb_tag)) begin
                    entries_d[i].vk = cdb_value;
                    entries_d[i].wk = 1'b0;
                end
            end
            if (issue && (ready_idx == IDX_W'(i))) begin
                entries_d[i].valid = 1'b0;
            end
            if (dispatch && (free_idx == IDX_W'(i))) begin
                entries_d[i] = new_entry;
            end
        end
    end

    assign count_d = count_q + CNT_W'(dispatch) - CNT_W'(issue);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q   <= '0;
            rs_full   <= 1'b0;
            alu_valid <= 1'b0;
            alu_op    <= OP_NOP;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_dest  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            rs_full <= (count_d >= CNT_W'(FULL_MARK));
            // Operand/dest registers hold their last issued values while idle.
            if (issue) begin
                alu_valid <= 1'b1;
                alu_op    <= issue_entry.op;
                alu_a     <= issue_entry.vj;
                alu_b     <= issue_entry.has_imm ? issue_entry.imm : issue_entry.vk;
                alu_dest  <= issue_entry.dest;
            end else begin
                alu_valid <= 1'b0;
                alu_op    <= OP_NOP;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed test-plan scenarios followed by random traffic, checked cycle by
// cycle against a slot-array reference model of the reservation station.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int DEPTH = 8;
    localparam int SLACK = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [4:0]        op_in;
    logic [31:0]       vj_in, vk_in, imm_in, cdb_value;
    logic [3:0]        qj_in, qk_in, dest_in, cdb_tag;
    logic              qj_wait_in, qk_wait_in, has_imm_in, cdb_valid;
    logic              rs_full, alu_valid;
    logic [4:0]        alu_op;
    logic [31:0]       alu_a, alu_b;
    logic [3:0]        alu_dest;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .op_in      (op_in),
        .vj_in      (vj_in),
        .vk_in      (vk_in),
        .qj_in      (qj_in),
        .qk_in      (qk_in),
        .qj_wait_in (qj_wait_in),
        .qk_wait_in (qk_wait_in),
        .imm_in     (imm_in),
        .has_imm_in (has_imm_in),
        .dest_in    (dest_in),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .rs_full    (rs_full),
        .alu_valid  (alu_valid),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_dest   (alu_dest)
    );

    typedef struct {
        bit        busy;
        bit [4:0]  op;
        bit [31:0] a_val;
        bit [31:0] b_val;
        bit [3:0]  a_tag;
        bit [3:0]  b_tag;
        bit        a_pend;
        bit        b_pend;
        bit [3:0]  dest;
    } slot_t;

    slot_t     slots [DEPTH];
    int        occupancy;
    int        n_vec;
    int        n_err;
    bit        x_valid;
    bit [4:0]  x_op;
    bit [31:0] x_a, x_b;
    bit [3:0]  x_dest;
    bit        x_full;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: operand B folds the immediate in at dispatch, so issue just reads a_val/b_val.
    task automatic model_step();
        int pick;
        int hole;
        if (!rst || flush) begin
            foreach (slots[i]) slots[i].busy = 1'b0;
            occupancy = 0;
            x_valid = 1'b0; x_op = OP_NOP; x_a = '0; x_b = '0; x_dest = '0; x_full = 1'b0;
            return;
        end
        pick = -1;
        hole = -1;
        foreach (slots[i]) begin
            if (pick < 0 && slots[i].busy && !slots[i].a_pend && !slots[i].b_pend) pick = i;
            if (hole < 0 && !slots[i].busy) hole = i;
        end
        if (cdb_valid) begin
            foreach (slots[i]) begin
                if (slots[i].busy && slots[i].a_pend && slots[i].a_tag == cdb_tag) begin
                    slots[i].a_val = cdb_value; slots[i].a_pend = 1'b0;
                end
                if (slots[i].busy && slots[i].b_pend && slots[i].b_tag == cdb_tag) begin
                    slots[i].b_val = cdb_value; slots[i].b_pend = 1'b0;
                end
            end
        end
        if (pick >= 0) begin
            x_valid = 1'b1; x_op = slots[pick].op; x_a = slots[pick].a_val;
            x_b = slots[pick].b_val; x_dest = slots[pick].dest;
            slots[pick].busy = 1'b0;
            occupancy--;
        end else begin
            x_valid = 1'b0; x_op = OP_NOP;
        end
        if (op_in != OP_NOP && hole >= 0) begin
            slot_t s;
            s.busy   = 1'b1;
            s.op     = op_in;
            s.dest   = dest_in;
            s.a_tag  = qj_in;
            s.a_pend = qj_wait_in && !(cdb_valid && cdb_tag == qj_in);
            s.a_val  = qj_wait_in ? cdb_value : vj_in;
            s.b_tag  = qk_in;
            s.b_pend = !has_imm_in && qk_wait_in && !(cdb_valid && cdb_tag == qk_in);
            s.b_val  = has_imm_in ? imm_in : (qk_wait_in ? cdb_value : vk_in);
            slots[hole] = s;
            occupancy++;
        end
        x_full = (DEPTH - occupancy) <= SLACK;
    endtask

    task automatic set_idle();
        rst = 1'b1; flush = 1'b0; op_in = OP_NOP;
        vj_in = '0; vk_in = '0; imm_in = '0; qj_in = '0; qk_in = '0; dest_in = '0;
        qj_wait_in = 1'b0; qk_wait_in = 1'b0; has_imm_in = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic drive(input bit [4:0] op, input bit [31:0] vj, input bit [31:0] vk,
                         input bit [3:0] qj, input bit [3:0] qk, input bit wj, input bit wk,
                         input bit [31:0] imm, input bit himm, input bit [3:0] dest);
        op_in = op; vj_in = vj; vk_in = vk; qj_in = qj; qk_in = qk;
        qj_wait_in = wj; qk_wait_in = wk; imm_in = imm; has_imm_in = himm; dest_in = dest;
    endtask

    task automatic bcast(input bit [3:0] tag, input bit [31:0] value);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_val("rs_full",   32'(rs_full),   32'(x_full));
        check_val("alu_valid", 32'(alu_valid), 32'(x_valid));
        check_val("alu_op",    32'(alu_op),    32'(x_op));
        check_val("alu_a",     alu_a,          x_a);
        check_val("alu_b",     alu_b,          x_b);
        check_val("alu_dest",  32'(alu_dest),  32'(x_dest));
        set_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        occupancy = 0;
        foreach (slots[i]) slots[i] = '{default: '0};
        set_idle();

        // Reset then idle
        rst = 1'b0; tick();
        rst = 1'b0; tick();
        tick();

        // Ready dispatch, then immediate operand with a pending (ignored) source 2
        drive(5'd3, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd2); tick();
        tick(); tick();
        drive(5'd4, 32'd10, 32'd0, 4'd0, 4'd9, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1, 4'd1); tick();
        tick(); tick();

        // Wake-up from a later broadcast, then from a same-cycle broadcast
        drive(5'd5, 32'd0, 32'd8, 4'd6, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd3); tick();
        tick(); tick(); tick();
        bcast(4'd6, 32'h1234); tick();
        tick(); tick();
        drive(5'd6, 32'd0, 32'd9, 4'd6, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd4);
        bcast(4'd6, 32'h5678); tick();
        tick(); tick();

        // Fill all entries with waiting ops, then an over-full dispatch that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            drive(5'd7, 32'd0, 32'(i), 4'(i), 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'(i));
            tick();
        end
        check_val("full_before_drop", 32'(rs_full), 32'd1);
        drive(5'd8, 32'hAA, 32'hBB, 4'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd15); tick();
        tick();
        bcast(4'd5, 32'h55); tick();
        bcast(4'd1, 32'h11); tick();
        tick(); tick();
        bcast(4'd0, 32'h10); tick();
        tick();

        // Flush with 5 live entries, then reset with 5 live entries
        flush = 1'b1; tick();
        for (int t = 2; t < 8; t++) begin bcast(4'(t), 32'(t)); tick(); end
        for (int i = 0; i < 5; i++) begin
            drive(5'd9, 32'd0, 32'd1, 4'(i + 8), 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 4'(i));
            tick();
        end
        rst = 1'b0; tick();
        for (int t = 8; t < 13; t++) begin bcast(4'(t), 32'(t)); tick(); end

        // Random traffic; dispatch only when the model says a slot is free
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) rst = 1'b0;
            if ($urandom_range(0, 149) == 0) flush = 1'b1;
            if (occupancy < DEPTH && $urandom_range(0, 1) == 1) begin
                drive(5'($urandom_range(0, 30)), $urandom, $urandom,
                      4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, 1'($urandom_range(0, 3) == 0), 4'($urandom));
            end
            if ($urandom_range(0, 1) == 1) bcast(4'($urandom_range(0, 7)), $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
